wb_write_queue: RTL
===================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; power of two and at least 2.
REQ-002 Parameter ADDR_W, 5, register address width.
REQ-003 Parameter DATA_W, 32, register data width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-006 rdy  input  1  global ready; when 0, all state and outputs hold.
REQ-007 a_valid  input  1  ALU-path writeback request.
REQ-008 a_addr  input  ADDR_W  ALU-path destination register.
REQ-009 a_data  input  DATA_W  ALU-path result.
REQ-010 b_valid  input  1  load-path writeback request.
REQ-011 b_addr  input  ADDR_W  load-path destination register.
REQ-012 b_data  input  DATA_W  load-path result.
REQ-013 in_ready  output  1  queue can accept both paths this cycle.
REQ-014 we  output  1  regfile write enable, registered.
REQ-015 waddr  output  ADDR_W  regfile write address, registered.
REQ-016 wdata  output  DATA_W  regfile write data, registered.
REQ-017 q_addr  input  ADDR_W  pending-value lookup address.
REQ-018 q_hit  output  1  q_addr has a pending, not-yet-retired write.
REQ-019 q_data  output  DATA_W  newest pending value for q_addr.
REQ-020 empty  output  1  no queued entries and we=0.

Function
REQ-021 The block SHALL be a circular FIFO with head and tail pointers wrapping modulo DEPTH and an occupancy count from 0 to DEPTH.
REQ-022 in_ready SHALL equal (count <= DEPTH-2), combinationally, and SHALL be 0 while rst=0.
REQ-023 On a rising edge with rdy=1 and in_ready=1, each path with valid=1 and addr!=0 SHALL be enqueued; writes to address 0 SHALL be discarded.
REQ-024 When both paths enqueue in the same cycle, A SHALL occupy the older slot and B the newer slot, including when a_addr equals b_addr.
REQ-025 Valid inputs presented while in_ready=0 SHALL be ignored; the sender holds them until in_ready=1.
REQ-026 On each rising edge with rdy=1: if count>0 before the edge, pop the head into we=1, waddr and wdata; otherwise we<=0, and waddr and wdata hold.
REQ-027 Push and pop in the same edge SHALL both take effect: count_next = count + pushes - pop.
REQ-028 Latency: an entry enqueued into an empty queue at edge N SHALL appear on we/waddr/wdata after edge N+1; entries retire one per rdy cycle in FIFO order.
REQ-029 q_hit SHALL be 1 when q_addr!=0 and it matches a valid queue entry or waddr with we=1; otherwise q_hit=0 and q_data=0.
REQ-030 q_data SHALL come from the youngest match; queue entries are younger than the output register, and tail-side entries are younger than head-side entries.
REQ-031 q_hit, q_data, in_ready and empty SHALL be combinational from the current state and q_addr only.
REQ-032 When rdy=0, pointers, count, queue contents and we/waddr/wdata SHALL hold their values, and no push or pop SHALL occur.

Reset
REQ-033 While rst=0: count=0, pointers=0, we=0, waddr=0, wdata=0, q_hit=0, q_data=0, empty=1 and in_ready=0, asynchronously.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries without issuing any further write.
REQ-035 On the first edge after rst deasserts, in_ready SHALL be 1.

Verification
REQ-036 Single write: a_valid=1, a_addr=5, a_data=0x1234 at edge N on an empty queue -> we=1, waddr=5, wdata=0x1234 after edge N+1, then we=0.
REQ-037 Dual same-address write: a=(7,0xA), b=(7,0xB) in one cycle -> q_addr=7 gives q_hit=1, q_data=0xB; retire order is 0xA then 0xB.
REQ-038 x0 filter: a_valid=1, a_addr=0 and b_valid=0 -> count stays 0, we stays 0, empty stays 1.
REQ-039 Backpressure at DEPTH=4: dual pushes for 2 cycles with continuous drain -> in_ready=0 when count=3, inputs ignored, no entry lost or duplicated.
REQ-040 rdy stall: rdy=0 for 3 cycles with count=2 -> we/waddr/wdata and count unchanged; draining resumes in order when rdy=1.
REQ-041 Reset mid-flight: rst=0 with count=3 -> we=0 immediately; after release, empty=1 and no stale write occurs.

Source files
------------

// File: rtl/wb_write_queue.sv
// wb_write_queue
//
// Purpose:
//   Register-file writeback queue. Two producers (the ALU path "a" and the
//   load path "b") may each hand over one register write per cycle. Writes
//   are buffered in a circular FIFO and retired one per cycle to the
//   register file through a registered write port. A lookup port lets the
//   pipeline forward the newest value still in flight for any register.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous reset, active low
//   rdy      in   global ready; when low every piece of state holds
//   a_valid  in   ALU-path write request
//   a_addr   in   ALU-path destination register
//   a_data   in   ALU-path result
//   b_valid  in   load-path write request
//   b_addr   in   load-path destination register
//   b_data   in   load-path result
//   in_ready out  queue has room for both paths this cycle
//   we       out  register-file write enable (registered)
//   waddr    out  register-file write address (registered)
//   wdata    out  register-file write data (registered)
//   q_addr   in   forwarding lookup address
//   q_hit    out  q_addr has a write still in flight
//   q_data   out  newest in-flight value for q_addr
//   empty    out  nothing queued and no write on the output port

module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Both paths may push in one cycle, so two free slots are needed.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [ADDR_W-1:0] ent_addr_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              a_push;
  logic              b_push;
  logic              pop;
  logic [CNT_W-1:0]  push_cnt;
  logic [PTR_W-1:0]  b_slot;
  logic [PTR_W-1:0]  look_idx;

  // Status outputs. in_ready is gated by reset so that no producer hands
  // over a write while the queue is being cleared.
  always_comb begin
    in_ready = rst && (count_q <= READY_MAX);
    empty    = (count_q == '0) && !we_q;
  end

  // Push/pop decisions. Writes to register 0 are dropped at the door.
  always_comb begin
    a_push   = rdy && in_ready && a_valid && (a_addr != '0);
    b_push   = rdy && in_ready && b_valid && (b_addr != '0);
    pop      = rdy && (count_q != '0);
    push_cnt = {{(CNT_W-1){1'b0}}, a_push} + {{(CNT_W-1){1'b0}}, b_push};
    // B lands one slot behind A when both push, keeping A older.
    b_slot   = a_push ? (tail_q + PTR_ONE) : tail_q;
  end

  // Next-state for queue storage, pointers and the registered write port.
  // Pop reads the head before any push can touch it: a push only writes
  // free slots, and pushes are only allowed with two slots free.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (rdy) begin
      if (pop) begin
        we_d    = 1'b1;
        waddr_d = ent_addr_q[head_q];
        wdata_d = ent_data_q[head_q];
        head_d  = head_q + PTR_ONE;
      end else begin
        we_d = 1'b0;
      end
      if (a_push) begin
        ent_addr_d[tail_q] = a_addr;
        ent_data_d[tail_q] = a_data;
      end
      if (b_push) begin
        ent_addr_d[b_slot] = b_addr;
        ent_data_d[b_slot] = b_data;
      end
      tail_d  = tail_q + push_cnt[PTR_W-1:0];
      count_d = count_q + push_cnt - (pop ? CNT_ONE : '0);
    end
  end

  // Forwarding lookup. Candidates are scanned oldest first (output
  // register, then head towards tail) so the last match wins and the
  // youngest pending value is returned.
  always_comb begin
    q_hit    = 1'b0;
    q_data   = '0;
    look_idx = '0;
    if (q_addr != '0) begin
      if (we_q && (waddr_q == q_addr)) begin
        q_hit  = 1'b1;
        q_data = wdata_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        look_idx = head_q + PTR_W'(k);
        if ((CNT_W'(k) < count_q) && (ent_addr_q[look_idx] == q_addr)) begin
          q_hit  = 1'b1;
          q_data = ent_data_q[look_idx];
        end
      end
    end
  end

  // State registers. Reset wipes queued entries so nothing stale can
  // ever be retired after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ent_addr_q <= '{default: '0};
      ent_data_q <= '{default: '0};
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule
